// File: rtl/clock_display_mux.sv
// Multiplexed 4-digit MM:SS seven-segment driver with a frame-coherent input snapshot.
// Optional build macro COLON_BLINK_EN blinks the colon (dp) on seconds parity.
module clock_display_mux #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_DASH = 7'b0111111;
  localparam logic [6:0]  SEG_OFF  = 7'h7F;

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  dig_q, dig_d;
  logic [5:0]  snap_s_q, snap_s_d;
  logic [5:0]  snap_m_q, snap_m_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;

  logic        slot_end;
  logic [5:0]  field;
  logic [3:0]  digit_val;
  logic [6:0]  digit_code;
  logic        colon;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = SEG_OFF;
    endcase
  endfunction

  // Snapshot only at the very end of a frame so one frame never mixes two input values.
  always_comb begin
    slot_end = (cnt_q == LAST_CNT);
    cnt_d    = slot_end ? 16'd0 : cnt_q + 16'd1;
    dig_d    = slot_end ? dig_q + 2'd1 : dig_q;
    snap_s_d = snap_s_q;
    snap_m_d = snap_m_q;
    if (slot_end && dig_q == 2'd3) begin
      snap_s_d = seconds;
      snap_m_d = minutes;
    end
  end

  always_comb begin
    field      = dig_q[1] ? snap_m_q : snap_s_q;
    digit_val  = dig_q[0] ? 4'(field / 6'd10) : 4'(field % 6'd10);
    digit_code = (field > 6'd59) ? SEG_DASH : encode(digit_val);
`ifdef COLON_BLINK_EN
    colon      = snap_s_q[0];
`else
    colon      = 1'b0;
`endif
  end

  // Blank every digit for the first cycle of its slot to avoid ghosting between digits.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = 4'hF;
    dp_d  = 1'b1;
    if (cnt_q != 16'd0) begin
      seg_d = digit_code;
      an_d  = ~(4'b0001 << dig_q);
      dp_d  = (dig_q == 2'd2) ? colon : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 16'd0;
      dig_q    <= 2'd0;
      snap_s_q <= 6'd0;
      snap_m_q <= 6'd0;
      seg_q    <= SEG_OFF;
      an_q     <= 4'hF;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      snap_s_q <= snap_s_d;
      snap_m_q <= snap_m_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: doc/clock_display_mux.md
CLOCK_DISPLAY_MUX -- requirements
Module: clock_display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seconds  input  6  binary seconds from the clock counter, nominal 0..59.
REQ-005 minutes  input  6  binary minutes from the clock counter, nominal 0..59.
REQ-006 seg  output  7  active-low segments {g,f,e,d,c,b,a}, seg[0]=a.
REQ-007 an  output  4  active-low digit enables; an[0]=seconds ones, an[1]=seconds tens, an[2]=minutes ones, an[3]=minutes tens.
REQ-008 dp  output  1  active-low decimal point (colon substitute).

Function
REQ-009 Prescale counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-010 2-bit digit index dig SHALL increment, 3 wrapping to 0, in the cycle cnt==SCAN_DIV-1.
REQ-011 Snapshot registers snap_s/snap_m SHALL load seconds/minutes in the cycle cnt==SCAN_DIV-1 and dig==3, so a frame never mixes two input values.
REQ-012 Inputs SHALL have no effect on outputs except through the snapshot.
REQ-013 Each field SHALL be split into tens=v/10 and ones=v%10 from the snapshot.
REQ-014 A snapshot field value >59 SHALL display dash (7'b0111111) on both its digits.
REQ-015 Encoding 0..9 (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 seg, an, dp SHALL be registered, computed from the current cnt/dig/snapshot, and visible one cycle later.
REQ-017 Anti-ghosting: when cnt==0, the registered outputs SHALL be an=4'b1111, seg=7'h7F, dp=1.
REQ-018 Otherwise an SHALL drive exactly one bit low, at position dig, with seg carrying that digit's code.
REQ-019 dp SHALL be 1 on every digit other than dig==2.
REQ-020 Frame period SHALL be 4*SCAN_DIV cycles; each digit is lit SCAN_DIV-1 cycles per frame.

Reset
REQ-021 While reset is high: cnt=0, dig=0, snap_s=0, snap_m=0, seg=7'h7F, an=4'hF, dp=1.
REQ-022 Reset SHALL override all counting in the same cycle, including mid-slot and mid-frame.
REQ-023 After reset the display SHALL show 00:00 until the first snapshot.

Configuration
REQ-024 Macro COLON_BLINK_EN controls the colon.
REQ-025 COLON_BLINK_EN defined: dp on dig==2 SHALL be 0 (lit) when snap_s[0]==0 and 1 when snap_s[0]==1, giving a 1 s colon blink.
REQ-026 COLON_BLINK_EN undefined: dp on dig==2 SHALL be 0 (lit) steadily.
REQ-027 Either way, dp SHALL remain 1 during the blanking cycle.

Verification (SCAN_DIV=4, 16-cycle frame)
REQ-028 Reset 3 cycles then release with seconds=0, minutes=0 -> first output cycle an=1111; then an=1110 with seg=1000000 for 3 cycles; dig advances every 4 cycles.
REQ-029 Hold seconds=37, minutes=12 across one full frame -> next frame shows an0=1111000(7), an1=0110000(3), an2=0100100(2), an3=1111001(1).
REQ-030 Change seconds 37->38 mid-frame (dig==1) -> current frame still shows 37; the change appears only after the dig==3 snapshot.
REQ-031 Drive seconds=63, minutes=59 -> an0/an1 show 0111111 (dash); an2/an3 show 9/5.
REQ-032 Assert reset while dig==2, cnt==2 -> next cycle an=1111, seg=7F, dp=1; after release, counting restarts at dig=0 and shows 00:00.
REQ-033 COLON_BLINK_EN defined, seconds=4 then 5 -> dp=0 on the an2 slot for 4, dp=1 for 5. Undefined -> dp=0 on the an2 slot for both.
